// File: rtl/dual_port_ram_cfg_pkg.sv
// Shared definitions for the configurable dual-port RAM and its clear sequencer.
// Contents:
//   RAM_MODE_ASYNC / RAM_MODE_SYNC : values for the SYNC_READ parameter
//   clr_state_e                    : clear sequencer state encoding (IDLE, CLEAR)
//   byte_merge()                   : lane-masked word merge, shared by byte-enabled memories
package dual_port_ram_cfg_pkg;

  localparam int RAM_MODE_ASYNC = 32'sd0;
  localparam int RAM_MODE_SYNC  = 32'sd1;

  // byte_merge works on a fixed maximum width so it can be shared by memories of
  // different word sizes; callers zero-extend their operands and truncate the result.
  localparam int MERGE_MAX_W     = 32'sd256;
  localparam int MERGE_MAX_LANES = MERGE_MAX_W / 32'sd8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Lanes with lane_mask[i]=1 take new_word, the rest keep old_word.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]     old_word,
    input logic [MERGE_MAX_W-1:0]     new_word,
    input logic [MERGE_MAX_LANES-1:0] lane_mask
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_LANES; i++) begin
      if (lane_mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_ram_cfg_ram_clear_seq.sv
// Clear sequencer: after reset walks every address once, asking the RAM to write
// the fill value, then parks in IDLE.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   busy        : high while the sequence runs (exactly 2**ADDR_W cycles)
//   clear_done  : one-cycle pulse on the first IDLE cycle after a sequence
//   clr_we      : fill-write request for this cycle
//   clr_addr    : address being filled this cycle
module ram_clear_seq
  import dual_port_ram_cfg_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              busy,
  output logic              clear_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam clr_state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  clr_state_e        state_r;
  clr_state_e        next_state_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [ADDR_W-1:0] next_cnt_s;
  logic              clear_done_r;
  logic              next_done_s;

  // State, fill counter and done-pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= RESET_STATE;
      clr_cnt_r    <= '0;
      clear_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      clr_cnt_r    <= next_cnt_s;
      clear_done_r <= next_done_s;
    end
  end

  // Next-state logic: the last address is written on the cycle that leaves CLEAR,
  // and the counter increment wraps it back to 0 for the next sequence.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = clr_cnt_r;
    next_done_s  = 1'b0;
    case (state_r)
      CLEAR: begin
        next_cnt_s = clr_cnt_r + CNT_ONE;
        if (clr_cnt_r == LAST_ADDR) begin
          next_state_s = IDLE;
          next_done_s  = 1'b1;
        end else begin
          next_state_s = CLEAR;
        end
      end
      IDLE: begin
        next_state_s = IDLE;
        next_cnt_s   = clr_cnt_r;
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = '0;
      end
    endcase
  end

  assign busy       = (state_r == CLEAR);
  assign clear_done = clear_done_r;
  assign clr_we     = (state_r == CLEAR);
  assign clr_addr   = clr_cnt_r;

endmodule

// File: rtl/dual_port_ram_cfg.sv
// Configurable dual-port RAM: port A read/write with byte-lane enables, port B
// read-only, optional registered read, and a post-reset zero-fill sequencer.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   we         : byte-lane write enables for port A
//   address    : port A address;  DI : port A write data
//   DPRA       : port B read address
//   SPO, DPO   : port A / port B read data (forced to 0 while busy)
//   busy       : fill sequence running, user writes ignored
//   clear_done : one-cycle pulse when busy falls
module dual_port_ram_cfg
  import dual_port_ram_cfg_pkg::*;
#(
  parameter int              DATA_W         = 16,
  parameter int              ADDR_W         = 6,
  parameter int              SYNC_READ      = RAM_MODE_ASYNC,
  parameter int              WRITE_FIRST    = 0,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ADDR_W-1:0]     address,
  input  logic [ADDR_W-1:0]     DPRA,
  input  logic [DATA_W-1:0]     DI,
  output logic [DATA_W-1:0]     SPO,
  output logic [DATA_W-1:0]     DPO,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0]          mem_r [DEPTH];
  logic                       busy_s;
  logic                       clear_done_s;
  logic                       clr_we_s;
  logic [ADDR_W-1:0]          clr_addr_s;
  logic [DATA_W-1:0]          rd_a_s;
  logic [DATA_W-1:0]          rd_b_s;
  logic [MERGE_MAX_W-1:0]     merge_old_s;
  logic [MERGE_MAX_W-1:0]     merge_new_s;
  logic [MERGE_MAX_LANES-1:0] merge_mask_s;
  logic [DATA_W-1:0]          merged_s;
  logic                       user_wr_s;
  logic                       wr_en_s;
  logic [ADDR_W-1:0]          wr_addr_s;
  logic [DATA_W-1:0]          wr_data_s;

  ram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .CLK        (CLK),
    .RST        (RST),
    .busy       (busy_s),
    .clear_done (clear_done_s),
    .clr_we     (clr_we_s),
    .clr_addr   (clr_addr_s)
  );

  assign busy       = busy_s;
  assign clear_done = clear_done_s;

  assign rd_a_s = mem_r[address];
  assign rd_b_s = mem_r[DPRA];

  // Byte merge of the addressed word with DI; operands widened to the shared helper width.
  always_comb begin
    merge_old_s               = '0;
    merge_new_s               = '0;
    merge_mask_s              = '0;
    merge_old_s[DATA_W-1:0]   = rd_a_s;
    merge_new_s[DATA_W-1:0]   = DI;
    merge_mask_s[LANES-1:0]   = we;
    merged_s                  = DATA_W'(byte_merge(merge_old_s, merge_new_s, merge_mask_s));
  end

  // The fill sequencer owns the single write port while busy; user enables are dropped.
  always_comb begin
    user_wr_s = (~busy_s) & (|we);
    if (busy_s) begin
      wr_en_s   = clr_we_s;
      wr_addr_s = clr_addr_s;
      wr_data_s = CLEAR_VAL;
    end else begin
      wr_en_s   = user_wr_s;
      wr_addr_s = address;
      wr_data_s = merged_s;
    end
  end

  // Memory array write; the array itself has no reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  generate
    if (SYNC_READ == RAM_MODE_SYNC) begin : g_sync_read
      logic [DATA_W-1:0] spo_r;
      logic [DATA_W-1:0] dpo_r;

      // Registered read ports; port B is always read-first, port A optionally write-first.
      always_ff @(posedge CLK) begin
        if (RST || busy_s) begin
          spo_r <= '0;
          dpo_r <= '0;
        end else begin
          spo_r <= ((WRITE_FIRST != 0) && user_wr_s) ? merged_s : rd_a_s;
          dpo_r <= rd_b_s;
        end
      end

      assign SPO = spo_r;
      assign DPO = dpo_r;
    end else begin : g_async_read
      assign SPO = busy_s ? '0 : rd_a_s;
      assign DPO = busy_s ? '0 : rd_b_s;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_cfg.sv
// Bench for dual_port_ram_cfg: four configurations share one stimulus stream
//   u0 async read, clear on reset (defaults)
//   u1 sync read, read-first        u2 sync read, write-first
//   u3 async read, no clear on reset
// A word-level model predicts every output each cycle; directed literal checks
// pin the model to hand-computed values.
module tb_dual_port_ram_cfg;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  we;
  logic [5:0]  address;
  logic [5:0]  DPRA;
  logic [15:0] DI;
  logic [15:0] spo [4];
  logic [15:0] dpo [4];
  logic        busy [4];
  logic        done [4];

  int n_tests = 0;
  int n_fail  = 0;
  int done_pulses0 = 0;
  int done_pulses3 = 0;

  always #5 CLK = ~CLK;

  dual_port_ram_cfg #(.SYNC_READ(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u0 (
    .CLK(CLK), .RST(RST), .we(we), .address(address), .DPRA(DPRA), .DI(DI),
    .SPO(spo[0]), .DPO(dpo[0]), .busy(busy[0]), .clear_done(done[0]));
  dual_port_ram_cfg #(.SYNC_READ(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u1 (
    .CLK(CLK), .RST(RST), .we(we), .address(address), .DPRA(DPRA), .DI(DI),
    .SPO(spo[1]), .DPO(dpo[1]), .busy(busy[1]), .clear_done(done[1]));
  dual_port_ram_cfg #(.SYNC_READ(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u2 (
    .CLK(CLK), .RST(RST), .we(we), .address(address), .DPRA(DPRA), .DI(DI),
    .SPO(spo[2]), .DPO(dpo[2]), .busy(busy[2]), .clear_done(done[2]));
  dual_port_ram_cfg #(.SYNC_READ(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u3 (
    .CLK(CLK), .RST(RST), .we(we), .address(address), .DPRA(DPRA), .DI(DI),
    .SPO(spo[3]), .DPO(dpo[3]), .busy(busy[3]), .clear_done(done[3]));

  localparam bit [3:0] SYNC_CFG = 4'b0110;
  localparam bit [3:0] WF_CFG   = 4'b0100;
  localparam bit [3:0] CLR_CFG  = 4'b0111;

  // Model state: array contents, which words hold defined data, remaining clear cycles.
  logic [15:0] m_mem   [4][64];
  bit          m_known [4][64];
  int          m_left  [4];
  bit          m_done  [4];
  logic [15:0] m_spo   [4];
  logic [15:0] m_dpo   [4];
  bit          model_valid = 1'b0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_left[i] = 0;
      m_done[i] = 1'b0;
      m_spo[i]  = 16'h0000;
      m_dpo[i]  = 16'h0000;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, for every configuration.
  task automatic model_step();
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic [15:0] merged;
    bit          b;
    bit          ka;
    for (int i = 0; i < 4; i++) begin
      b      = (m_left[i] > 0);
      rd_a   = m_mem[i][address];
      rd_b   = m_mem[i][DPRA];
      ka     = m_known[i][address];
      merged = rd_a;
      if (we[0]) merged[7:0]  = DI[7:0];
      if (we[1]) merged[15:8] = DI[15:8];
      if (RST || b) begin
        m_spo[i] = 16'h0000;
        m_dpo[i] = 16'h0000;
      end else begin
        m_spo[i] = (WF_CFG[i] && we != 2'b00) ? merged : rd_a;
        m_dpo[i] = rd_b;
      end
      if (b) begin
        m_mem[i][64 - m_left[i]]   = 16'h0000;
        m_known[i][64 - m_left[i]] = 1'b1;
        m_left[i]                  = m_left[i] - 1;
      end else if (we != 2'b00) begin
        m_mem[i][address]   = merged;
        m_known[i][address] = ka || (we == 2'b11);
      end
      if (RST) begin
        m_left[i] = CLR_CFG[i] ? 64 : 0;
        m_done[i] = 1'b0;
      end else begin
        m_done[i] = b && (m_left[i] == 0);
      end
    end
    if (RST) model_valid = 1'b1;
  endtask

  always @(posedge CLK) model_step();

  // Per-cycle comparison of all four DUTs against the model.
  always @(negedge CLK) begin
    if (model_valid) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("u%0d.busy", i), {15'd0, busy[i]}, {15'd0, (m_left[i] > 0)});
        check($sformatf("u%0d.clear_done", i), {15'd0, done[i]}, {15'd0, m_done[i]});
        if (SYNC_CFG[i]) begin
          check($sformatf("u%0d.SPO", i), spo[i], m_spo[i]);
          check($sformatf("u%0d.DPO", i), dpo[i], m_dpo[i]);
        end else if (m_left[i] > 0) begin
          check($sformatf("u%0d.SPO", i), spo[i], 16'h0000);
          check($sformatf("u%0d.DPO", i), dpo[i], 16'h0000);
        end else begin
          if (m_known[i][address]) check($sformatf("u%0d.SPO", i), spo[i], m_mem[i][address]);
          if (m_known[i][DPRA])    check($sformatf("u%0d.DPO", i), dpo[i], m_mem[i][DPRA]);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (done[0] === 1'b1) done_pulses0++;
    if (done[3] === 1'b1) done_pulses3++;
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    int  nb;
    bit  restarted;
    RST = 1'b1; we = 2'b00; address = 6'd0; DPRA = 6'd0; DI = 16'h0000;
    step();
    RST = 1'b0;

    // Clear after first reset: 64 busy cycles, pulse on the 65th.
    nb = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (busy[0]) nb++;
      else break;
    end
    check("busy_cycles", nb[15:0], 16'd64);
    check("clear_done_pulse", {15'd0, done[0]}, 16'd1);
    check("u3_busy_never", {15'd0, busy[3]}, 16'd0);
    @(negedge CLK);
    check("clear_done_low", {15'd0, done[0]}, 16'd0);

    // Every word reads zero on both ports.
    for (int a = 0; a < 64; a++) begin
      step();
      address = 6'(a);
      DPRA    = 6'(63 - a);
      @(negedge CLK);
      check("sweep_spo", spo[0], 16'h0000);
      check("sweep_dpo", dpo[0], 16'h0000);
    end

    // Full write, then a low-lane-only write.
    step(); address = 6'd5; DPRA = 6'd5; DI = 16'hABCD; we = 2'b11;
    step(); we = 2'b00;
    @(negedge CLK);
    check("full_write_spo", spo[0], 16'hABCD);
    check("same_addr_dpo", dpo[0], 16'hABCD);
    step(); we = 2'b01; DI = 16'h1234;
    step(); we = 2'b00;
    @(negedge CLK);
    check("lane_write_spo", spo[0], 16'hAB34);

    // Read-during-write ordering in the registered configurations.
    step(); address = 6'd9; DPRA = 6'd0; DI = 16'h1111; we = 2'b11;
    step(); we = 2'b00; DPRA = 6'd9;
    step(); DI = 16'h2222; we = 2'b11;
    step(); we = 2'b00;
    @(negedge CLK);
    check("rf_spo_old", spo[1], 16'h1111);
    check("rf_dpo_old", dpo[1], 16'h1111);
    check("wf_spo_new", spo[2], 16'h2222);
    check("wf_dpo_old", dpo[2], 16'h1111);
    step();
    @(negedge CLK);
    check("rf_spo_next", spo[1], 16'h2222);
    check("rf_dpo_next", dpo[1], 16'h2222);
    check("wf_dpo_next", dpo[2], 16'h2222);
    check("async_same_addr", dpo[0], spo[0] === 16'h2222 ? 16'h2222 : 16'hDEAD);

    // Word that must survive a reset when clear is disabled.
    step(); address = 6'd3; DPRA = 6'd3; DI = 16'h5A5A; we = 2'b11;
    step(); we = 2'b00;
    @(negedge CLK);
    check("u3_pre_reset", spo[3], 16'h5A5A);

    // Second reset; write attempt at clear cycle 10, reset again at cycle 30.
    step(); done_pulses0 = 0; done_pulses3 = 0; RST = 1'b1; address = 6'd63;
    step(); RST = 1'b0;
    nb = 0;
    restarted = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (!busy[0]) break;
      nb++;
      if (!restarted && nb == 10) begin
        #1; we = 2'b11; DI = 16'hFFFF;
      end
      if (!restarted && nb == 11) begin
        #1; we = 2'b00;
      end
      if (!restarted && nb == 30) begin
        step(); RST = 1'b1;
        step(); RST = 1'b0;
        nb = 0;
        restarted = 1'b1;
      end
    end
    check("restart_busy_cycles", nb[15:0], 16'd64);
    check("restart_done_pulse", {15'd0, done[0]}, 16'd1);
    @(negedge CLK);
    check("single_done_pulse", done_pulses0[15:0], 16'd1);
    check("u3_no_done", done_pulses3[15:0], 16'd0);
    check("busy_write_ignored", spo[0], 16'h0000);
    check("u3_idle_write", spo[3], 16'hFFFF);
    step(); address = 6'd3; DPRA = 6'd63;
    @(negedge CLK);
    check("u3_survives_reset", spo[3], 16'h5A5A);
    check("u0_addr63_dpo", dpo[0], 16'h0000);
    check("u0_addr3_cleared", spo[0], 16'h0000);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, tests run %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
